// File: rtl/sample_lag_frontend_pkg.sv
// Shared parameters and types for the echo-cancellation front end, converter and filter stages.
package sample_lag_frontend_pkg;
  localparam int DATA_W    = 16;
  localparam int CNT_W     = 13;
  localparam int LAG_W     = 4;
  localparam int MIN_CYCLE = 2;

  // Where the value published at a period boundary comes from.
  typedef enum logic [1:0] {
    SRC_HOLD   = 2'd0,
    SRC_PEND   = 2'd1,
    SRC_BYPASS = 2'd2
  } pub_src_e;
endpackage

// File: rtl/sample_lag_frontend_if.sv
// ADC sample handshake: the converter drives valid/data, the front end returns ready.
interface sample_lag_frontend_if #(
  parameter int DATA_W = sample_lag_frontend_pkg::DATA_W
);
  logic              adc_valid;
  logic [DATA_W-1:0] adc_data;
  logic              adc_ready;

  modport master (output adc_valid, output adc_data, input adc_ready);
  modport slave  (input adc_valid, input adc_data, output adc_ready);
endinterface

// File: rtl/sample_lag_frontend_lag_ring_buffer.sv
// Delay line for the echo reference: one write port, one registered read-before-write read port.
module sample_lag_frontend_lag_ring_buffer #(
  parameter int AW = sample_lag_frontend_pkg::LAG_W,
  parameter int DW = sample_lag_frontend_pkg::DATA_W
) (
  input  logic          clk_operation,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);
  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic [DW-1:0] rd_data_q, rd_data_d;

  // The read samples the old contents, so an address equal to wr_addr returns the previous lap.
  always_comb begin
    mem_d     = mem_q;
    rd_data_d = rd_data_q;
    if (we) begin
      rd_data_d      = mem_q[rd_addr];
      mem_d[wr_addr] = wr_data;
    end
  end

  always_ff @(posedge clk_operation) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_data_q <= '0;
    end else begin
      mem_q     <= mem_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;
endmodule

// File: rtl/sample_lag_frontend.sv
// Period counter, single-entry ADC pending buffer and once-per-period publish of sig16b and its delayed copy.
module sample_lag_frontend
  import sample_lag_frontend_pkg::*;
#(
  parameter int DATA_W = sample_lag_frontend_pkg::DATA_W,
  parameter int CNT_W  = sample_lag_frontend_pkg::CNT_W,
  parameter int LAG_W  = sample_lag_frontend_pkg::LAG_W
) (
  input  logic               clk_operation,
  input  logic               rst,
  input  logic               enable,
  input  logic [CNT_W-1:0]   sampling_cycle,
  input  logic [LAG_W-1:0]   lag_sel,
  sample_lag_frontend_if.slave adc,
  output logic [CNT_W-1:0]   sampling_cycle_counter,
  output logic               sample_strobe,
  output logic [DATA_W-1:0]  sig16b,
  output logic [DATA_W-1:0]  sig16b_lag,
  output logic               lag_valid,
  output logic               underrun
);
  localparam logic [LAG_W-1:0] FILL_MAX = '1;

  logic [CNT_W-1:0]  cnt_q, cnt_d, cycle_q, cycle_d, eff_in;
  logic              pend_full_q, pend_full_d;
  logic [DATA_W-1:0] pend_data_q, pend_data_d;
  logic [DATA_W-1:0] sig_q, sig_d;
  logic              strobe_q, strobe_d;
  logic              lag_valid_q, lag_valid_d;
  logic              lag_zero_q, lag_zero_d;
  logic              underrun_q, underrun_d;
  logic [LAG_W-1:0]  fill_q, fill_d, wr_ptr_q, wr_ptr_d, rd_addr;
  logic              boundary, accept;
  pub_src_e          src;
  logic [DATA_W-1:0] pub_data, ring_rd_data;

  assign eff_in        = (sampling_cycle < CNT_W'(MIN_CYCLE)) ? CNT_W'(MIN_CYCLE) : sampling_cycle;
  assign boundary      = enable && (cnt_q == cycle_q - CNT_W'(1));
  assign adc.adc_ready = !pend_full_q && !rst;
  assign accept        = adc.adc_valid && adc.adc_ready;
  assign rd_addr       = wr_ptr_q - lag_sel;

  always_comb begin
    if (pend_full_q)  src = SRC_PEND;
    else if (accept)  src = SRC_BYPASS;
    else              src = SRC_HOLD;
    case (src)
      SRC_PEND:   pub_data = pend_data_q;
      SRC_BYPASS: pub_data = adc.adc_data;
      default:    pub_data = sig_q;
    endcase
  end

  always_comb begin
    cnt_d       = cnt_q;
    cycle_d     = cycle_q;
    pend_full_d = pend_full_q;
    pend_data_d = pend_data_q;
    sig_d       = sig_q;
    lag_valid_d = lag_valid_q;
    lag_zero_d  = lag_zero_q;
    underrun_d  = underrun_q;
    fill_d      = fill_q;
    wr_ptr_d    = wr_ptr_q;
    strobe_d    = boundary;
    if (enable) cnt_d = boundary ? '0 : cnt_q + CNT_W'(1);
    if (boundary) begin
      cycle_d     = eff_in;
      sig_d       = pub_data;
      pend_full_d = 1'b0;
      if (src == SRC_HOLD) underrun_d = 1'b1;
      wr_ptr_d    = wr_ptr_q + LAG_W'(1);
      fill_d      = (fill_q == FILL_MAX) ? fill_q : fill_q + LAG_W'(1);
      lag_valid_d = (fill_d >= lag_sel);
      lag_zero_d  = (lag_sel == '0);
    end else if (accept) begin
      pend_full_d = 1'b1;
      pend_data_d = adc.adc_data;
    end
  end

  // The first period after reset uses whatever sampling_cycle is presented while rst is held.
  always_ff @(posedge clk_operation) begin
    if (rst) begin
      cnt_q       <= '0;
      cycle_q     <= eff_in;
      pend_full_q <= 1'b0;
      pend_data_q <= '0;
      sig_q       <= '0;
      strobe_q    <= 1'b0;
      lag_valid_q <= 1'b0;
      lag_zero_q  <= 1'b0;
      underrun_q  <= 1'b0;
      fill_q      <= '0;
      wr_ptr_q    <= '0;
    end else begin
      cnt_q       <= cnt_d;
      cycle_q     <= cycle_d;
      pend_full_q <= pend_full_d;
      pend_data_q <= pend_data_d;
      sig_q       <= sig_d;
      strobe_q    <= strobe_d;
      lag_valid_q <= lag_valid_d;
      lag_zero_q  <= lag_zero_d;
      underrun_q  <= underrun_d;
      fill_q      <= fill_d;
      wr_ptr_q    <= wr_ptr_d;
    end
  end

  sample_lag_frontend_lag_ring_buffer #(.AW(LAG_W), .DW(DATA_W)) u_lag_ring_buffer (
    .clk_operation (clk_operation),
    .rst           (rst),
    .we            (boundary),
    .wr_addr       (wr_ptr_q),
    .wr_data       (pub_data),
    .rd_addr       (rd_addr),
    .rd_data       (ring_rd_data)
  );

  // Zero lag bypasses the ring since its read port only returns the previous lap.
  assign sig16b_lag             = lag_valid_q ? (lag_zero_q ? sig_q : ring_rd_data) : '0;
  assign sampling_cycle_counter = cnt_q;
  assign sample_strobe          = strobe_q;
  assign sig16b                 = sig_q;
  assign lag_valid              = lag_valid_q;
  assign underrun               = underrun_q;
endmodule
